tff_bank: RTL and testbench
===========================

// Module: tff_bank
// PURPOSE
//  Parametrised bank of WIDTH toggle flip-flops. Successor to the single T-FF.
//  Adds selectable active clock edge, parallel load and enable.
//  Adds cascade modes that chain the bits into a synchronous up or down counter
//  with a wrap (terminal-count) flag.
//  Used as a toggle/divider register or a small counter in student datapath labs.
// PARAMETERS
//  WIDTH    4   number of T-FF channels (>=1)
//  NEGEDGE  1   1: state updates on falling clk edge; 0: rising edge
// PORTS
//  clk       in   1      system clock; single clock domain
//  rst       in   1      synchronous, active-high reset, sampled on the active edge
//  en        in   1      global toggle enable
//  mode      in   2      0 independent, 1 cascade up, 2 cascade down, 3 hold
//  t         in   WIDTH  per-channel toggle request
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value written to q on load
//  q         out  WIDTH  flip-flop outputs (registered)
//  toggled   out  WIDTH  bits that flipped at the last active edge (registered)
//  tc        out  1      one-edge pulse: counter wrapped at the last active edge
// BEHAVIOUR
//  - All state changes happen only on the active edge selected by NEGEDGE.
//    There is no combinational path from the inputs to the outputs.
//  - Reset values: q = 0, toggled = 0, tc = 0.
//    Unlike the old block, no initial statement is used; rst is required.
//  - Priority at each active edge: rst > load > en/mode.
//  - Load: q <= load_val, toggled <= 0, tc <= 0. This applies regardless of en and mode.
//  - en = 0 (and no rst/load): q holds, toggled <= 0, tc <= 0.
//  - en = 1: per-bit toggle enable te[i] is
//     mode 0: te[i] = t[i]
//     mode 1: te[i] = t[i] & (&q[i-1:0]); te[0] = t[0]  (carry chain)
//     mode 2: te[i] = t[i] & ~(|q[i-1:0]); te[0] = t[0] (borrow chain)
//     mode 3: te = 0 (hold)
//    Then q <= q ^ te and toggled <= te.
//  - The chain uses the q value from before the edge. With t all ones, mode 1
//    gives q+1 mod 2^WIDTH and mode 2 gives q-1 mod 2^WIDTH: one step per active edge.
//  - A t[i] = 0 bit inside the chain stays held, but it does not block the carry
//    to higher bits. Only q gates the chain, never t.
//  - tc rules:
//     mode 1: tc <= 1 when q goes from all-ones to 0.
//     mode 2: tc <= 1 when q goes from 0 to all-ones.
//     Otherwise tc <= 0, including mode 0 and mode 3.
//     tc lasts exactly one active-edge period.
//  - Changing mode takes effect at the next active edge. q is not disturbed by a
//    mode change.
//  - rst asserted mid-count clears q, toggled and tc at that edge. The count
//    resumes from 0 on the first edge after rst deasserts.
//  - WIDTH = 1: both cascade modes reduce to a plain T-FF. tc then pulses on each
//    1->0 toggle (mode 1) or each 0->1 toggle (mode 2).
// TESTING (WIDTH=4, NEGEDGE=1, clk period 80 ns)
//  1. rst=1 for 2 falling edges -> q=0000, toggled=0000, tc=0;
//     rising edges never change q.
//  2. mode 0, en=1, t=0101, 3 falling edges -> q: 0101, 0000, 0101;
//     toggled=0101 each edge.
//  3. mode 1, en=1, t=1111, from 0, 16 falling edges -> q counts 1..15 then 0;
//     tc=1 only after the 15->0 edge.
//  4. mode 2, load with load_val=0010, then 3 edges -> q 0001, 0000, 1111;
//     tc=1 after the 0000->1111 edge only.
//  5. mode 1 counting, load=1 and en=1 on the same edge with load_val=1110
//     -> q=1110, tc=0. The next edge gives 1111, then 0000 with tc=1.
//  6. rst=1 mid-count at q=0110 -> q=0000 at that edge.
//     en=0 for 2 edges -> q holds and toggled=0.

Source files
------------

// File: rtl/tff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tff_bank
// Brief    : Bank of WIDTH toggle flip-flops with load, enable, selectable
//            active edge and up/down cascade modes with a wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tff_bank #(
    parameter int WIDTH   = 4,
    parameter bit NEGEDGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] toggled,
    output logic             tc
);

    localparam logic [1:0] c_MODE_IND  = 2'd0;
    localparam logic [1:0] c_MODE_UP   = 2'd1;
    localparam logic [1:0] c_MODE_DOWN = 2'd2;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_toggled;
    logic             r_tc;

    logic [WIDTH-1:0] w_te;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap;
    logic [WIDTH-1:0] w_q_d;
    logic [WIDTH-1:0] w_tog_d;
    logic             w_tc_d;

    // Carry/borrow chains look only at the pre-edge q; t never breaks the chain.
    always_comb begin
        logic w_all1;
        logic w_all0;
        w_te   = '0;
        w_all1 = 1'b1;
        w_all0 = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                c_MODE_IND:  w_te[i] = t[i];
                c_MODE_UP:   w_te[i] = t[i] & w_all1;
                c_MODE_DOWN: w_te[i] = t[i] & w_all0;
                default:     w_te[i] = 1'b0;
            endcase
            w_all1 = w_all1 & r_q[i];
            w_all0 = w_all0 & ~r_q[i];
        end
    end

    assign w_q_nxt = r_q ^ w_te;

    always_comb begin
        w_wrap = 1'b0;
        if (mode == c_MODE_UP)
            w_wrap = (&r_q) & ~(|w_q_nxt);
        else if (mode == c_MODE_DOWN)
            w_wrap = ~(|r_q) & (&w_q_nxt);
    end

    always_comb begin
        w_q_d   = r_q;
        w_tog_d = '0;
        w_tc_d  = 1'b0;
        if (rst) begin
            w_q_d = '0;
        end else if (load) begin
            w_q_d = load_val;
        end else if (en) begin
            w_q_d   = w_q_nxt;
            w_tog_d = w_te;
            w_tc_d  = w_wrap;
        end
    end

    generate
        if (NEGEDGE) begin : g_negedge
            always_ff @(negedge clk) begin
                r_q       <= w_q_d;
                r_toggled <= w_tog_d;
                r_tc      <= w_tc_d;
            end
        end else begin : g_posedge
            always_ff @(posedge clk) begin
                r_q       <= w_q_d;
                r_toggled <= w_tog_d;
                r_tc      <= w_tc_d;
            end
        end
    endgenerate

    assign q       = r_q;
    assign toggled = r_toggled;
    assign tc      = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_tff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_bank
// Brief    : Scoreboard bench for tff_bank (WIDTH=4, falling-edge active).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_bank;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] tog;
        logic             tc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [WIDTH-1:0] t = '0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] toggled;
    logic             tc;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    tff_bank #(.WIDTH(WIDTH), .NEGEDGE(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .t        (t),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .toggled  (toggled),
        .tc       (tc)
    );

    always #40 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one vector ahead of the falling edge and queue its expected result.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [WIDTH-1:0] tt, input logic ld,
                        input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] eq,
                        input logic [WIDTH-1:0] et, input logic etc);
        exp_t x;
        @(posedge clk);
        rst = r; en = e; mode = m; t = tt; load = ld; load_val = lv;
        x.q = eq; x.tog = et; x.tc = etc;
        sb.push_back(x);
    endtask

    // Monitor: after each falling edge, compare against the oldest entry,
    // then confirm the following rising edge leaves q untouched.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #20;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("q", q, x.q);
                check("toggled", toggled, x.tog);
                check("tc", {{(WIDTH-1){1'b0}}, tc}, {{(WIDTH-1){1'b0}}, x.tc});
                @(posedge clk);
                #1;
                check("q_rise_stable", q, x.q);
            end
        end
    end

    initial begin
        // Reset
        step(1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(1, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // Independent toggles
        step(0, 1, 0, 4'b0101, 0, 4'b0000, 4'b0101, 4'b0101, 0);
        step(0, 1, 0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0101, 0);
        step(0, 1, 0, 4'b0101, 0, 4'b0000, 4'b0101, 4'b0101, 0);
        step(1, 1, 0, 4'b0101, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // Up count 1..15 then wrap to 0 with tc
        for (int k = 1; k <= 16; k++) begin
            logic [WIDTH-1:0] kq, kp;
            kq = WIDTH'(k);
            kp = WIDTH'(k - 1);
            step(0, 1, 1, 4'b1111, 0, 4'b0000, kq, kq ^ kp, k == 16);
        end
        // Down count after load
        step(0, 1, 2, 4'b1111, 1, 4'b0010, 4'b0010, 4'b0000, 0);
        step(0, 1, 2, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0011, 0);
        step(0, 1, 2, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0001, 0);
        step(0, 1, 2, 4'b1111, 0, 4'b0000, 4'b1111, 4'b1111, 1);
        step(0, 1, 2, 4'b1111, 0, 4'b0000, 4'b1110, 4'b0001, 0);
        // Up count, load wins over en on the same edge
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b1111, 4'b0001, 0);
        step(0, 1, 1, 4'b1111, 1, 4'b1110, 4'b1110, 4'b0000, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b1111, 4'b0001, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0000, 4'b1111, 1);
        // Count to 0110, reset mid-count, resume, then disable
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0001, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0010, 4'b0011, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0011, 4'b0001, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0100, 4'b0111, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0101, 4'b0001, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0110, 4'b0011, 0);
        step(1, 1, 1, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 1, 1, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0001, 0);
        step(0, 0, 1, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0000, 0);
        step(0, 0, 1, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0000, 0);
        // t=0 hole in the carry chain: bit1 holds, bit2 still sees the carry
        step(0, 1, 1, 4'b1101, 1, 4'b0011, 4'b0011, 4'b0000, 0);
        step(0, 1, 1, 4'b1101, 0, 4'b0000, 4'b0110, 4'b0101, 0);
        // Hold mode keeps q; switch back to independent leaves q intact
        step(0, 1, 3, 4'b1111, 0, 4'b0000, 4'b0110, 4'b0000, 0);
        step(0, 1, 0, 4'b1000, 0, 4'b0000, 4'b1110, 4'b1000, 0);
        // Up wrap with t bit0 clear: no wrap since q stays nonzero
        step(0, 1, 1, 4'b1110, 1, 4'b1111, 4'b1111, 4'b0000, 0);
        step(0, 1, 1, 4'b1110, 0, 4'b0000, 4'b0001, 4'b1110, 0);

        @(posedge clk);
        en = 1'b0; load = 1'b0; rst = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
